dma_read_cmd_splitter: RTL
==========================

Name: dma_read_cmd_splitter

Overview:
- Sits between the benchmark DMA read engine and the DMA core read-command port.
- Accepts arbitrary-length read commands, each with a 64-bit address and a 32-bit byte length.
- Emits sub-commands that never cross a 4 KB boundary and never exceed MAX_LEN bytes.
- Caps in-flight sub-commands at MAX_OUTSTANDING, counting completions via the `last` beat of the returning read data stream, which passes through unchanged.

Parameters:
- MAX_LEN, 4096: maximum sub-command length in bytes. Power of two, 64..4096.
- MAX_OUTSTANDING, 16: maximum issued sub-commands without a completed last beat, 1..255.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- s_cmd_valid  in  1  upstream command valid
- s_cmd_ready  out  1  upstream command ready
- s_cmd_address  in  64  upstream byte address (64 B aligned)
- s_cmd_length  in  32  upstream byte length (multiple of 64)
- m_cmd_valid  out  1  sub-command valid to DMA core
- m_cmd_ready  in  1  DMA core ready
- m_cmd_address  out  64  sub-command address
- m_cmd_length  out  32  sub-command length
- s_data_valid/ready/last  in/out/in  1 each  read data from DMA core
- s_data_data  in  512  read data
- m_data_valid/ready/last  out/in/out  1 each  read data to engine
- m_data_data  out  512  read data
- outstanding  out  8  current in-flight sub-command count
- status_cmd_in  out  32  accepted upstream commands
- status_sub_cmd  out  32  issued sub-commands
- status_err  out  32  dropped zero-length commands

Behaviour:
- Reset: state IDLE; s_cmd_ready=0 during reset, then 1 in IDLE. m_cmd_valid=0; m_cmd_address/length=0; outstanding=0; all status counters=0.
- States: IDLE, CALC, ISSUE.
- IDLE:
  - s_cmd_ready=1.
  - On handshake, latch cur_addr=s_cmd_address, rem=s_cmd_length, and increment status_cmd_in.
  - If s_cmd_length==0: increment status_err, stay in IDLE, emit nothing.
  - Otherwise go to CALC.
- CALC (1 cycle):
  - chunk = min(rem, MAX_LEN, 4096 - cur_addr[11:0]). Compute in 32 bits; the boundary term ranges 64..4096.
  - Register m_cmd_address=cur_addr, m_cmd_length=chunk, then go to ISSUE.
- ISSUE:
  - m_cmd_valid = (outstanding < MAX_OUTSTANDING).
  - Address and length are held stable while valid and not ready.
  - On handshake: cur_addr += chunk; rem -= chunk; outstanding++; status_sub_cmd++.
  - If rem == chunk → IDLE, otherwise → CALC.
- Latency: the first sub-command is valid 2 cycles after the upstream handshake. Steady state is one sub-command per 2 cycles.
- Data path: purely combinational pass-through. m_data_* = s_data_*, s_data_ready = m_data_ready.
- Completion: outstanding-- on s_data_valid & s_data_ready & s_data_last.
  - Simultaneous issue and completion in one cycle: outstanding unchanged.
  - Completion while outstanding==0: ignored (saturate at 0), and status_err increments.
- Throttle: when outstanding reaches MAX_OUTSTANDING, m_cmd_valid drops the next cycle. It reasserts the cycle after a completion brings outstanding below the limit. A completion in the same cycle as the stall is counted.
- Address arithmetic: 64-bit, wraps modulo 2^64 with no special handling.
- Status counters: wrap modulo 2^32.
- Reset mid-operation:
  - All state is cleared immediately.
  - The in-progress command is abandoned.
  - Data beats arriving after reset pass through but do not decrement below 0.

Test Plan:
1. Addr 0x1000, len 8192, MAX_LEN 4096 → two sub-commands: (0x1000, 4096), (0x2000, 4096). status_sub_cmd=2.
2. Addr 0x0FC0, len 256 → (0x0FC0, 64), (0x1000, 192). No 4 KB crossing.
3. MAX_LEN 1024, addr 0x0, len 4096, m_cmd_ready held low 5 cycles on the first sub-command → address/length stable while stalled; 4 sub-commands, each 1024 B, addresses 0x0/0x400/0x800/0xC00.
4. MAX_OUTSTANDING 2, len 16384, no data returned → exactly 2 sub-commands issued, then m_cmd_valid=0 and outstanding=2. One last beat → a third sub-command issues; outstanding stays 2.
5. len 0 → no m_cmd_valid, status_err=1, status_cmd_in=1, s_cmd_ready back to 1 the next cycle. A last beat with outstanding 0 → status_err=2, outstanding stays 0.
6. Assert rstn low during ISSUE of a 3-sub-command transfer → next cycle m_cmd_valid=0, outstanding=0, counters 0. A new command afterwards completes normally.

Source files
------------

// File: rtl/dma_read_cmd_splitter.sv
// Splits arbitrary-length DMA read commands into sub-commands that stay inside
// one 4 KB page and never exceed MAX_LEN; throttles on in-flight sub-commands.
module dma_read_cmd_splitter #(
    parameter int unsigned MAX_LEN         = 4096,
    parameter int unsigned MAX_OUTSTANDING = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         s_cmd_valid,
    output logic         s_cmd_ready,
    input  logic [63:0]  s_cmd_address,
    input  logic [31:0]  s_cmd_length,
    output logic         m_cmd_valid,
    input  logic         m_cmd_ready,
    output logic [63:0]  m_cmd_address,
    output logic [31:0]  m_cmd_length,
    input  logic         s_data_valid,
    output logic         s_data_ready,
    input  logic         s_data_last,
    input  logic [511:0] s_data_data,
    output logic         m_data_valid,
    input  logic         m_data_ready,
    output logic         m_data_last,
    output logic [511:0] m_data_data,
    output logic [7:0]   outstanding,
    output logic [31:0]  status_cmd_in,
    output logic [31:0]  status_sub_cmd,
    output logic [31:0]  status_err
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        ISSUE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [63:0] cur_addr;
    logic [31:0] rem;
    logic [31:0] boundary;
    logic [31:0] chunk;
    logic        cmd_hs;
    logic        sub_hs;
    logic        done_beat;
    logic        orphan_beat;
    logic        last_sub;
    logic [1:0]  err_inc;

    assign m_data_valid = s_data_valid;
    assign m_data_last  = s_data_last;
    assign m_data_data  = s_data_data;
    assign s_data_ready = m_data_ready;

    // Bytes left in the current 4 KB page: 64..4096 for 64 B aligned addresses.
    assign boundary = 32'd4096 - {20'd0, cur_addr[11:0]};

    always_comb begin
        chunk = rem;
        if (chunk > MAX_LEN) chunk = MAX_LEN;
        if (chunk > boundary) chunk = boundary;
    end

    assign cmd_hs      = s_cmd_valid & s_cmd_ready;
    assign sub_hs      = m_cmd_valid & m_cmd_ready;
    assign done_beat   = s_data_valid & m_data_ready & s_data_last;
    assign orphan_beat = done_beat & ~sub_hs & (outstanding == '0);
    assign last_sub    = (rem == m_cmd_length);
    assign err_inc     = {1'b0, cmd_hs & (s_cmd_length == '0)} + {1'b0, orphan_beat};

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        s_cmd_ready = 1'b0;
        m_cmd_valid = 1'b0;
        case (state)
            IDLE: begin
                s_cmd_ready = rstn;
                if (s_cmd_valid && rstn && s_cmd_length != '0) state_nxt = CALC;
            end
            CALC: state_nxt = ISSUE;
            ISSUE: begin
                m_cmd_valid = ({24'd0, outstanding} < MAX_OUTSTANDING);
                if (m_cmd_valid && m_cmd_ready) state_nxt = last_sub ? IDLE : CALC;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cur_addr       <= '0;
            rem            <= '0;
            m_cmd_address  <= '0;
            m_cmd_length   <= '0;
            outstanding    <= '0;
            status_cmd_in  <= '0;
            status_sub_cmd <= '0;
            status_err     <= '0;
        end else begin
            if (cmd_hs) begin
                cur_addr      <= s_cmd_address;
                rem           <= s_cmd_length;
                status_cmd_in <= status_cmd_in + 32'd1;
            end
            if (state == CALC) begin
                m_cmd_address <= cur_addr;
                m_cmd_length  <= chunk;
            end
            if (sub_hs) begin
                cur_addr       <= cur_addr + {32'd0, m_cmd_length};
                rem            <= rem - m_cmd_length;
                status_sub_cmd <= status_sub_cmd + 32'd1;
            end
            // An issue and a completion in the same cycle cancel out.
            if (sub_hs && !done_beat)
                outstanding <= outstanding + 8'd1;
            else if (!sub_hs && done_beat && outstanding != '0)
                outstanding <= outstanding - 8'd1;
            status_err <= status_err + {30'd0, err_inc};
        end
    end

endmodule
